// File: rtl/mtr_drv.sv
// Two-wheel motor drive: signed speed -> complementary PWM pairs with dead time,
// plus blanked over-current monitoring that latches a sticky shutdown.
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'd32,
  parameter logic [10:0] BLANK      = 11'd128,
  parameter logic [3:0]  OVR_LIMIT  = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        OVR_I_shtdwn
);

  localparam int NSIDE = 2;  // index 0 = left, 1 = right

  logic [10:0]      cnt_q, cnt_d;
  logic [10:0]      duty_q [NSIDE];
  logic [10:0]      duty_d [NSIDE];
  logic [NSIDE-1:0] pwm_sig_q, pwm_sig_d;
  logic [10:0]      nov_cnt_q [NSIDE];
  logic [10:0]      nov_cnt_d [NSIDE];
  logic [10:0]      on_cnt_q [NSIDE];
  logic [10:0]      on_cnt_d [NSIDE];
  logic [NSIDE-1:0] pwm1_q, pwm1_d;
  logic [NSIDE-1:0] pwm2_q, pwm2_d;
  logic             ovr_seen_q, ovr_seen_d;
  logic [3:0]       ovr_cnt_q, ovr_cnt_d;
  logic             shtdwn_q, shtdwn_d;

  logic [11:0]      spd [NSIDE];
  logic [NSIDE-1:0] ovr_i;
  logic [NSIDE-1:0] win_open;
  logic             ovr_hit;
  logic             period_end;

  // Clip to [-1024, 1023] and offset so zero speed maps to 50% duty.
  function automatic logic [10:0] spd_to_duty(input logic [11:0] speed);
    logic signed [11:0] s;
    s = signed'(speed);
    if (s > 12'sd1023)
      return 11'd2047;
    else if (s < -12'sd1024)
      return 11'd0;
    else
      return 11'(speed + 12'd1024);
  endfunction

  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;
  assign ovr_i  = {OVR_I_rght, OVR_I_lft};

  always_comb begin
    cnt_d      = cnt_q + 11'd1;
    period_end = (cnt_q == 11'h7FF);
    // Outputs use shtdwn_d so they drop on the same edge shutdown asserts.
    shtdwn_d   = shtdwn_q | (ovr_cnt_q >= OVR_LIMIT);

    for (int s = 0; s < NSIDE; s++) begin
      duty_d[s]    = period_end ? spd_to_duty(spd[s]) : duty_q[s];
      pwm_sig_d[s] = (cnt_q < duty_q[s]);

      if (pwm_sig_d[s] != pwm_sig_q[s])
        nov_cnt_d[s] = '0;
      else if (nov_cnt_q[s] < NONOVERLAP)
        nov_cnt_d[s] = nov_cnt_q[s] + 11'd1;
      else
        nov_cnt_d[s] = nov_cnt_q[s];

      pwm1_d[s] =  pwm_sig_q[s] & (nov_cnt_q[s] == NONOVERLAP) & ~shtdwn_d;
      pwm2_d[s] = ~pwm_sig_q[s] & (nov_cnt_q[s] == NONOVERLAP) & ~shtdwn_d;

      // on_cnt reads 0 on the first cycle a drive output is high.
      if ((pwm1_d[s] & ~pwm1_q[s]) | (pwm2_d[s] & ~pwm2_q[s]))
        on_cnt_d[s] = '0;
      else if ((pwm1_q[s] | pwm2_q[s]) && (on_cnt_q[s] != 11'h7FF))
        on_cnt_d[s] = on_cnt_q[s] + 11'd1;
      else
        on_cnt_d[s] = on_cnt_q[s];

      win_open[s] = (pwm1_q[s] | pwm2_q[s]) & (on_cnt_q[s] >= BLANK);
    end

    ovr_hit    = |(ovr_i & win_open);
    ovr_seen_d = ovr_seen_q | ovr_hit;
    ovr_cnt_d  = ovr_cnt_q;
    // A hit on the last cycle of a period still belongs to that period.
    if (period_end) begin
      ovr_seen_d = 1'b0;
      if (ovr_seen_q | ovr_hit)
        ovr_cnt_d = (ovr_cnt_q >= OVR_LIMIT) ? ovr_cnt_q : ovr_cnt_q + 4'd1;
      else
        ovr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pwm_sig_q  <= '0;
      pwm1_q     <= '0;
      pwm2_q     <= '0;
      ovr_seen_q <= 1'b0;
      ovr_cnt_q  <= '0;
      shtdwn_q   <= 1'b0;
      for (int s = 0; s < NSIDE; s++) begin
        duty_q[s]    <= 11'd1024;
        nov_cnt_q[s] <= '0;
        on_cnt_q[s]  <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      pwm_sig_q  <= pwm_sig_d;
      pwm1_q     <= pwm1_d;
      pwm2_q     <= pwm2_d;
      ovr_seen_q <= ovr_seen_d;
      ovr_cnt_q  <= ovr_cnt_d;
      shtdwn_q   <= shtdwn_d;
      for (int s = 0; s < NSIDE; s++) begin
        duty_q[s]    <= duty_d[s];
        nov_cnt_q[s] <= nov_cnt_d[s];
        on_cnt_q[s]  <= on_cnt_d[s];
      end
    end
  end

  assign PWM1_lft     = pwm1_q[0];
  assign PWM2_lft     = pwm2_q[0];
  assign PWM1_rght    = pwm1_q[1];
  assign PWM2_rght    = pwm2_q[1];
  assign OVR_I_shtdwn = shtdwn_q;

endmodule
